// File: rtl/prism_cnt_pkg.sv
// Shared register map, PRELOAD bit positions and bus helpers for the PRISM countdown-counter bank.
package prism_cnt_pkg;

  localparam logic [5:0] REG_CTRL     = 6'h00;
  localparam logic [5:0] REG_STATUS   = 6'h04;
  localparam logic [5:0] REG_IRQ_EN   = 6'h08;
  localparam logic [5:0] REG_PRESCALE = 6'h0C;
  localparam logic [5:0] REG_CH_BASE  = 6'h10;
  localparam int unsigned CH_STRIDE   = 8;

  localparam int unsigned AUTO_RELOAD_BIT     = 31;
  localparam int unsigned USE_PRESCALE_BIT    = 30;
  localparam int unsigned CTRL_ENABLE_BIT     = 0;
  localparam int unsigned CTRL_SOFT_CLEAR_BIT = 1;

  localparam logic [1:0] WR_SIZE_32 = 2'b10;

  function automatic logic [5:0] preload_addr(input int unsigned ch);
    return REG_CH_BASE + 6'(ch * CH_STRIDE);
  endfunction

  function automatic logic [5:0] count_addr(input int unsigned ch);
    return preload_addr(ch) + 6'd4;
  endfunction

endpackage

// File: rtl/prism_cnt_channel.sv
// Single countdown channel: preload, mode bits, prioritised count update, zero detect and set pulse.
// The use_prescale bit exists only when PRISM_CNT_PRESCALE_EN is defined.
module prism_cnt_channel
  import prism_cnt_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             preload_we,
  input  logic             count_we,
  input  logic [31:0]      wdata,
  input  logic             soft_clear,
  input  logic             run,
  input  logic             tick,
  input  logic             load_en,
  input  logic             dec_en,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      preload_rd,
  output logic             zero,
  output logic             set_zero
);

  logic [CNT_W-1:0] preload;
  logic             auto_reload;
  logic             use_prescale;
  logic             ch_tick;
  logic             load_go;
  logic             dec_go;
  logic             unused_wdata;

  assign unused_wdata = &{1'b0, wdata};

`ifdef PRISM_CNT_PRESCALE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      use_prescale <= 1'b0;
    end else if (preload_we) begin
      use_prescale <= wdata[USE_PRESCALE_BIT];
    end
  end
`else
  logic unused_tick;
  assign unused_tick  = tick;
  assign use_prescale = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preload     <= '0;
      auto_reload <= 1'b0;
    end else if (preload_we) begin
      preload     <= wdata[CNT_W-1:0];
      auto_reload <= wdata[AUTO_RELOAD_BIT];
    end
  end

  assign ch_tick = use_prescale ? tick : 1'b1;
  assign load_go = load_en && run;
  // Decrement is the lowest-priority source; set_zero must only fire when it actually wins.
  assign dec_go   = dec_en && run && ch_tick && !soft_clear && !count_we && !load_go;
  assign set_zero = dec_go && (count == CNT_W'(1));
  assign zero     = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (soft_clear) begin
      count <= '0;
    end else if (count_we) begin
      count <= wdata[CNT_W-1:0];
    end else if (load_go) begin
      count <= preload;
    end else if (dec_go) begin
      if (count > CNT_W'(1)) begin
        count <= count - CNT_W'(1);
      end else if (count == CNT_W'(1)) begin
        count <= '0;
      end else if (auto_reload) begin
        count <= preload;
      end
    end
  end

  always_comb begin
    preload_rd                   = '0;
    preload_rd[CNT_W-1:0]        = preload;
    preload_rd[AUTO_RELOAD_BIT]  = auto_reload;
    preload_rd[USE_PRESCALE_BIT] = use_prescale;
  end

endmodule

// File: rtl/prism_counter_bank.sv
// Countdown-counter bank: bus decode, shared prescaler, sticky STATUS and maskable irq over NUM_CH channels.
// Define PRISM_CNT_PRESCALE_EN to build the shared prescaler and per-channel use_prescale bit.
module prism_counter_bank
  import prism_cnt_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        address,
  input  logic [31:0]       data_in,
  input  logic [1:0]        data_write_n,
  input  logic [1:0]        data_read_n,
  output logic [31:0]       data_out,
  output logic              data_ready,
  input  logic [NUM_CH-1:0] load_en,
  input  logic [NUM_CH-1:0] dec_en,
  input  logic              halt,
  output logic [NUM_CH-1:0] zero_flag,
  output logic              irq
);

  logic              wr_en;
  logic              soft_clear;
  logic              enable;
  logic              run;
  logic              tick;
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] status_clr;
  logic [NUM_CH-1:0] set_zero;
  logic [CNT_W-1:0]  ch_count   [NUM_CH];
  logic [31:0]       ch_preload [NUM_CH];
  logic              unused_bus;

  assign unused_bus = &{1'b0, data_read_n, data_in};

  assign wr_en      = (data_write_n == WR_SIZE_32);
  assign soft_clear = wr_en && (address == REG_CTRL) && data_in[CTRL_SOFT_CLEAR_BIT];
  assign run        = enable && !halt;
  assign status_clr = (wr_en && (address == REG_STATUS)) ? data_in[NUM_CH-1:0] : '0;
  assign data_ready = 1'b1;
  assign irq        = |(status & irq_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable <= 1'b0;
      irq_en <= '0;
    end else begin
      if (wr_en && (address == REG_CTRL)) begin
        enable <= data_in[CTRL_ENABLE_BIT];
      end
      if (wr_en && (address == REG_IRQ_EN)) begin
        irq_en <= data_in[NUM_CH-1:0];
      end
    end
  end

  // Hardware set is OR'd in after the W1C mask so it wins a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= '0;
    end else if (soft_clear) begin
      status <= '0;
    end else begin
      status <= (status & ~status_clr) | set_zero;
    end
  end

`ifdef PRISM_CNT_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] presc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
    end else if (wr_en && (address == REG_PRESCALE)) begin
      prescale <= data_in[PRESCALE_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (soft_clear) begin
      presc_cnt <= '0;
    end else if (run) begin
      if (presc_cnt == '0) begin
        presc_cnt <= prescale;
      end else begin
        presc_cnt <= presc_cnt - PRESCALE_W'(1);
      end
    end
  end

  assign tick = run && (presc_cnt == '0);
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    prism_cnt_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .preload_we (wr_en && (address == preload_addr(i))),
      .count_we   (wr_en && (address == count_addr(i))),
      .wdata      (data_in),
      .soft_clear (soft_clear),
      .run        (run),
      .tick       (tick),
      .load_en    (load_en[i]),
      .dec_en     (dec_en[i]),
      .count      (ch_count[i]),
      .preload_rd (ch_preload[i]),
      .zero       (zero_flag[i]),
      .set_zero   (set_zero[i])
    );
  end

  always_comb begin
    data_out = '0;
    case (address)
      REG_CTRL:     data_out[CTRL_ENABLE_BIT] = enable;
      REG_STATUS:   data_out[NUM_CH-1:0]      = status;
      REG_IRQ_EN:   data_out[NUM_CH-1:0]      = irq_en;
`ifdef PRISM_CNT_PRESCALE_EN
      REG_PRESCALE: data_out[PRESCALE_W-1:0]  = prescale;
`endif
      default:      ;
    endcase
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (address == preload_addr(i)) begin
        data_out = ch_preload[i];
      end
      if (address == count_addr(i)) begin
        data_out[CNT_W-1:0] = ch_count[i];
      end
    end
  end

endmodule
